// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch display path: digit indices, segment and
// anode patterns, and the six-digit BCD bundle.
package stopwatch_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  localparam logic [2:0] IDX_CENT = 3'd0;
  localparam logic [2:0] IDX_DEC  = 3'd1;
  localparam logic [2:0] IDX_USEC = 3'd2;
  localparam logic [2:0] IDX_DSEC = 3'd3;
  localparam logic [2:0] IDX_UMIN = 3'd4;
  localparam logic [2:0] IDX_DMIN = 3'd5;

  // Segment order is {g,f,e,d,c,b,a}, all active-low.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = '1;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t dmin;
    bcd_t umin;
    bcd_t dsec;
    bcd_t usec;
    bcd_t dec;
    bcd_t cent;
  } digits_t;

  // Active-low one-hot anode for a digit index.
  function automatic logic [NUM_DIGITS-1:0] anode_onehot(input logic [2:0] idx);
    logic [NUM_DIGITS-1:0] onehot;
    onehot = '0;
    onehot[idx] = 1'b1;
    return ~onehot;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes show a dash.
module bcd_to_seg7
  import stopwatch_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = 7'b1000000;
      4'd1:    o_seg = 7'b1111001;
      4'd2:    o_seg = 7'b0100100;
      4'd3:    o_seg = 7'b0110000;
      4'd4:    o_seg = 7'b0011001;
      4'd5:    o_seg = 7'b0010010;
      4'd6:    o_seg = 7'b0000010;
      4'd7:    o_seg = 7'b1111000;
      4'd8:    o_seg = 7'b0000000;
      4'd9:    o_seg = 7'b0010000;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stopwatch_display_mux.sv
// Six-digit multiplexed 7-segment driver for the stopwatch with lap freeze and paused blink.
// Define STOPWATCH_LEADING_ZERO_BLANK_EN to suppress leading zero minute digits.
module stopwatch_display_mux
  import stopwatch_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 12500000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stay,
  input  logic                  lap,
  input  logic [3:0]            centesimas,
  input  logic [3:0]            decimas,
  input  logic [3:0]            unidades_segundo,
  input  logic [2:0]            decenas_segundo,
  input  logic [3:0]            unidades_minuto,
  input  logic [2:0]            decenas_minuto,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frozen
);

  localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [SCAN_W-1:0]     r_scan_cnt;
  logic [2:0]            r_idx;
  logic [BLINK_W-1:0]    r_blink_cnt;
  logic                  r_blink_phase;
  logic                  r_frozen;
  digits_t               r_snap;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;
  logic                  r_dp;

  digits_t               w_live;
  digits_t               w_src;
  bcd_t                  w_digit;
  logic [6:0]            w_seg;
  logic                  w_scan_wrap;
  logic                  w_blink_wrap;
  logic                  w_blinking;
  logic [NUM_DIGITS-1:0] w_an_d;
  logic [6:0]            w_seg_d;
  logic                  w_dp_d;

  always_comb begin
    w_live      = '0;
    w_live.cent = centesimas;
    w_live.dec  = decimas;
    w_live.usec = unidades_segundo;
    w_live.dsec = {1'b0, decenas_segundo};
    w_live.umin = unidades_minuto;
    w_live.dmin = {1'b0, decenas_minuto};
  end

  assign w_src        = r_frozen ? r_snap : w_live;
  assign w_scan_wrap  = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign w_blink_wrap = (r_blink_cnt == BLINK_W'(BLINK_DIV - 1));
  // A paused display of all zeros is left steady; there is nothing to draw attention to.
  assign w_blinking   = !stay && !r_frozen && (w_live != '0);

  always_comb begin
    w_digit = w_src.cent;
    unique case (r_idx)
      IDX_CENT: w_digit = w_src.cent;
      IDX_DEC:  w_digit = w_src.dec;
      IDX_USEC: w_digit = w_src.usec;
      IDX_DSEC: w_digit = w_src.dsec;
      IDX_UMIN: w_digit = w_src.umin;
      IDX_DMIN: w_digit = w_src.dmin;
      default:  w_digit = w_src.cent;
    endcase
  end

  bcd_to_seg7 u_bcd_to_seg7 (
    .i_bcd (w_digit),
    .o_seg (w_seg)
  );

  always_comb begin
    w_an_d  = anode_onehot(r_idx);
    w_seg_d = w_seg;
    w_dp_d  = !((r_idx == IDX_USEC) || (r_idx == IDX_UMIN));
`ifdef STOPWATCH_LEADING_ZERO_BLANK_EN
    if ((r_idx == IDX_DMIN) && (w_src.dmin == 4'd0)) begin
      w_an_d = ANODE_OFF;
    end
    if ((r_idx == IDX_UMIN) && (w_src.dmin == 4'd0) && (w_src.umin == 4'd0)) begin
      w_an_d = ANODE_OFF;
      w_dp_d = 1'b1;
    end
`endif
    if (w_blinking && r_blink_phase) begin
      w_an_d  = ANODE_OFF;
      w_seg_d = SEG_BLANK;
      w_dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt    <= '0;
      r_idx         <= IDX_CENT;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_frozen      <= 1'b0;
      r_snap        <= '0;
      r_an          <= ANODE_OFF;
      r_seg         <= SEG_BLANK;
      r_dp          <= 1'b1;
    end else begin
      r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + SCAN_W'(1);
      if (w_scan_wrap) begin
        r_idx <= (r_idx == IDX_DMIN) ? IDX_CENT : r_idx + 3'd1;
      end
      r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + BLINK_W'(1);
      if (w_blink_wrap) begin
        r_blink_phase <= ~r_blink_phase;
      end
      if (lap) begin
        if (!r_frozen) begin
          r_snap   <= w_live;
          r_frozen <= 1'b1;
        end else begin
          r_frozen <= 1'b0;
        end
      end
      r_an  <= w_an_d;
      r_seg <= w_seg_d;
      r_dp  <= w_dp_d;
    end
  end

  assign an     = r_an;
  assign seg    = r_seg;
  assign dp     = r_dp;
  assign frozen = r_frozen;

endmodule

// File: tb/tb_stopwatch_display_mux.sv
// Self-checking bench for stopwatch_display_mux: decoder vector table, directed scan/lap/blink
// sequences and randomized traffic against a cycle-count based reference model.
module tb_stopwatch_display_mux;

  localparam int unsigned SCAN  = 4;
  localparam int unsigned BLINK = 16;

  logic       clk = 1'b0;
  logic       rst, stay, lap;
  logic [3:0] cent, dec, usec, umin;
  logic [2:0] dsec, dmin;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp, frozen;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: edges since reset, lap state and snapshot (index 0 = centesimas).
  int m_t;
  bit m_frozen;
  int m_snap[6];

  typedef struct {
    logic [3:0] bcd;
    logic [6:0] seg;
  } vec_t;
  vec_t vt[16];

  always #5 clk = ~clk;

  stopwatch_display_mux #(
    .SCAN_DIV  (SCAN),
    .BLINK_DIV (BLINK)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stay             (stay),
    .lap              (lap),
    .centesimas       (cent),
    .decimas          (dec),
    .unidades_segundo (usec),
    .decenas_segundo  (dsec),
    .unidades_minuto  (umin),
    .decenas_minuto   (dmin),
    .an               (an),
    .seg              (seg),
    .dp               (dp),
    .frozen           (frozen)
  );

  function automatic int live(input int i);
    case (i)
      0:       return int'(cent);
      1:       return int'(dec);
      2:       return int'(usec);
      3:       return int'(dsec);
      4:       return int'(umin);
      default: return int'(dmin);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  task automatic set_digits(input int dm, input int um, input int ds, input int us,
                            input int de, input int ce);
    dmin = 3'(dm); umin = 4'(um); dsec = 3'(ds); usec = 4'(us); dec = 4'(de); cent = 4'(ce);
  endtask

  // Predict the outputs after the coming edge, advance the model, then clock and compare.
  task automatic step();
    logic [5:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int         idx;
    int         src[6];
    bit         any, phase;
    if (rst) begin
      e_an = 6'h3F; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      idx   = (m_t / SCAN) % 6;
      phase = ((m_t / BLINK) % 2) == 1;
      any   = 1'b0;
      for (int i = 0; i < 6; i++) begin
        src[i] = m_frozen ? m_snap[i] : live(i);
        if (live(i) != 0) any = 1'b1;
      end
      e_an  = ~(6'b000001 << idx);
      e_seg = vt[src[idx]].seg;
      e_dp  = !(idx == 2 || idx == 4);
`ifdef STOPWATCH_LEADING_ZERO_BLANK_EN
      if (idx == 5 && src[5] == 0) e_an = 6'h3F;
      if (idx == 4 && src[5] == 0 && src[4] == 0) begin
        e_an = 6'h3F; e_dp = 1'b1;
      end
`endif
      if (!stay && !m_frozen && any && phase) begin
        e_an = 6'h3F; e_seg = 7'h7F; e_dp = 1'b1;
      end
    end
    if (rst) begin
      m_t = 0; m_frozen = 1'b0;
      for (int i = 0; i < 6; i++) m_snap[i] = 0;
    end else begin
      m_t++;
      if (lap) begin
        if (!m_frozen) begin
          for (int i = 0; i < 6; i++) m_snap[i] = live(i);
          m_frozen = 1'b1;
        end else begin
          m_frozen = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    check("an", int'(an), int'(e_an));
    check("seg", int'(seg), int'(e_seg));
    check("dp", int'(dp), int'(e_dp));
    check("frozen", int'(frozen), int'(m_frozen));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int blanked;
    int dm_lows;
    vt[0]  = '{4'd0,  7'b1000000}; vt[1]  = '{4'd1,  7'b1111001};
    vt[2]  = '{4'd2,  7'b0100100}; vt[3]  = '{4'd3,  7'b0110000};
    vt[4]  = '{4'd4,  7'b0011001}; vt[5]  = '{4'd5,  7'b0010010};
    vt[6]  = '{4'd6,  7'b0000010}; vt[7]  = '{4'd7,  7'b1111000};
    vt[8]  = '{4'd8,  7'b0000000}; vt[9]  = '{4'd9,  7'b0010000};
    vt[10] = '{4'd10, 7'b0111111}; vt[11] = '{4'd11, 7'b0111111};
    vt[12] = '{4'd12, 7'b0111111}; vt[13] = '{4'd13, 7'b0111111};
    vt[14] = '{4'd14, 7'b0111111}; vt[15] = '{4'd15, 7'b0111111};

    rst = 1'b1; stay = 1'b1; lap = 1'b0;
    set_digits(0, 0, 0, 0, 0, 0);
    m_t = 0; m_frozen = 1'b0;
    for (int i = 0; i < 6; i++) m_snap[i] = 0;
    run(2);

    // Decoder table on idx0, including the dash codes.
    for (int v = 0; v < 16; v++) begin
      rst = 1'b1; step();
      rst = 1'b0; cent = vt[v].bcd; step();
      check("tbl_seg", int'(seg), int'(vt[v].seg));
      check("tbl_an", int'(an), 6'h3E);
    end

    // Scan walk with 59:59.99 and stay high.
    rst = 1'b1; set_digits(5, 9, 5, 9, 9, 9); step();
    rst = 1'b0; run(SCAN * 6 * 2 + 3);

    // Lap freeze, changing live inputs, then release.
    rst = 1'b1; set_digits(0, 1, 2, 3, 4, 5); step();
    rst = 1'b0; run(3);
    lap = 1'b1; step(); lap = 1'b0;
    check("lap_frozen", int'(frozen), 1);
    set_digits(5, 8, 4, 7, 6, 9);
    run(SCAN * 6 * 2);
    lap = 1'b1; step(); lap = 1'b0;
    check("unlap_frozen", int'(frozen), 0);
    run(SCAN * 2);

    // Paused blink: exactly half of each 2*BLINK window is blanked.
    rst = 1'b1; stay = 1'b0; set_digits(0, 0, 0, 0, 0, 7); step();
    rst = 1'b0;
    blanked = 0;
    for (int i = 0; i < 2 * BLINK; i++) begin
      step();
      if (an == 6'h3F) blanked++;
    end
    check("blink_half", blanked, BLINK);
    set_digits(0, 0, 0, 0, 0, 0); run(2 * BLINK + 2);
    set_digits(1, 2, 3, 4, 5, 6); stay = 1'b1; run(2 * BLINK + 2);

    // Simultaneous reset and lap while frozen.
    lap = 1'b1; step(); lap = 1'b0; run(2);
    rst = 1'b1; lap = 1'b1; step();
    check("rst_lap_frozen", int'(frozen), 0);
    check("rst_lap_an", int'(an), 6'h3F);
    rst = 1'b0; lap = 1'b0;

    // Leading zero minutes.
    rst = 1'b1; set_digits(0, 0, 3, 0, 0, 0); step();
    rst = 1'b0;
    dm_lows = 0;
    for (int i = 0; i < SCAN * 6 * 2; i++) begin
      step();
      if (!an[5] || !an[4]) dm_lows++;
    end
`ifdef STOPWATCH_LEADING_ZERO_BLANK_EN
    check("lzb_minutes_off", dm_lows, 0);
`else
    check("lzb_minutes_on", dm_lows, SCAN * 2 * 2);
`endif
    set_digits(0, 1, 3, 0, 0, 0); run(SCAN * 6 + 2);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      lap = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 99) == 0) stay = ~stay;
      if ($urandom_range(0, 29) == 0) begin
        set_digits($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 7),
                   $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) set_digits(0, 0, 0, 0, 0, 0);
      end
      step();
    end
    rst = 1'b0; lap = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stopwatch_display_mux.md
Name: stopwatch_display_mux

Overview:
Downstream consumer of the stopwatch digit counters (centesimas, decimas, seconds units/tens, minutes units/tens). Time-multiplexes the six BCD digits onto a common 6-digit active-low 7-segment display, with mm.ss.dc separators. Adds a lap-freeze snapshot and a paused-state blink. Sits between the counter chain and the board display pins.

Parameters:
SCAN_DIV, 50000, clk cycles each digit is driven before advancing (≥2).
BLINK_DIV, 12500000, clk cycles per blink half-period while paused (≥2).

Ports:
clk  in  1  system clock
rst  in  1  reset
stay  in  1  counters running (1) / paused (0); same signal fed to counter chain
lap  in  1  single-cycle lap pulse, already debounced/synchronised upstream
centesimas  in  4  BCD hundredths
decimas  in  4  BCD tenths
unidades_segundo  in  4  BCD seconds units
decenas_segundo  in  3  seconds tens 0..5
unidades_minuto  in  4  BCD minutes units
decenas_minuto  in  3  minutes tens 0..5
an  out  6  digit anodes, active-low; an[0] = rightmost (centesimas)
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low
frozen  out  1  lap snapshot being displayed

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On rst: scan_cnt=0, idx=0, blink_cnt=0, blink_phase=0, frozen=0, snapshot=0; registered outputs an=6'b111111, seg=7'b1111111, dp=1. rst wins over lap in the same cycle.
- Scan: scan_cnt counts 0..SCAN_DIV-1; at terminal count it wraps to 0 and idx advances 0→1→…→5→0.
- Digit map: idx0 centesimas, 1 decimas, 2 seconds units, 3 seconds tens, 4 minutes units, 5 minutes tens. 3-bit inputs are zero-extended to 4 bits.
- Output latency: an/seg/dp are registered and reflect idx and digit source one cycle after idx changes. Exactly one anode is low when not blanked.
- Decode: 0..9 use standard patterns (0=1000000, 1=1111001, 8=0000000). Values 10..15 show a dash (0111111).
- dp is low on idx 2 and idx 4; high otherwise.
- Source select: frozen=0 uses live inputs; frozen=1 uses the snapshot registers.
- Lap: lap with frozen=0 captures all six live inputs, as sampled on that edge, into the snapshot and sets frozen=1. lap with frozen=1 clears frozen. The counters are not affected in either case.
- Blink: blink_cnt counts 0..BLINK_DIV-1 and toggles blink_phase at wrap. It runs freely and only affects output when blinking.
  - Blinking is active when stay=0, frozen=0, and any live digit is nonzero.
  - While blinking with blink_phase=1: an=111111, seg=1111111, dp=1.
  - When blinking is inactive, the display is always visible.
- Scan continues uninterrupted through blanking, freeze and pause.

Optional Feature:
STOPWATCH_LEADING_ZERO_BLANK_EN
- Defined:
  - idx5 anode is held high when its displayed value is 0.
  - idx4 anode is held high when both displayed minute digits are 0; dp on idx4 is also suppressed.
  - The rule applies to the selected source (live or snapshot).
- Undefined: all six digits are always driven.

Decomposition:
- Package stopwatch_pkg: NUM_DIGITS=6, digit index constants (IDX_CENT…IDX_DMIN), SEG_BLANK, SEG_DASH, ANODE_OFF, 4-bit BCD digit typedef.
- One sub-module, bcd_to_seg7: purely combinational 4-bit to 7-bit decoder including the dash case. Instantiated once, on the selected digit.

Test Plan:
- Reset/scan (SCAN_DIV=4): release rst with live digits 5,9,5,9,9,9 (dmin…cent) → an walks 111110, 111101, …, 011111 every 4 cycles; seg on idx0 = 0010000; dp low only with an=111011 and an=101111.
- Lap freeze: live 0,1,2,3,4,5 (dmin…cent), pulse lap, then change all inputs → frozen=1 and display keeps 0,1,2,3,4,5. A second lap → frozen=0 and live values appear within one scan slot.
- Blink (BLINK_DIV=16, stay=0, live cent=7): anodes all high for 16 cycles, then visible for 16, repeating. With all digits zero → never blanked. With stay=1 → never blanked.
- Invalid BCD: centesimas=4'hC → seg=0111111 when an[0] low.
- Simultaneous rst and lap → frozen=0 and outputs at reset values on the next cycle.
- Macro defined, digits 0,0,3,0,0,0 (dmin…cent): an[5] and an[4] never go low and idx4 dp is never asserted. With dmin=0, umin=1: an[4] is driven, an[5] is not.
